// File: rtl/ps2_byte_rx.sv
// ps2_byte_rx
// Deserialises the PS/2 ps2_clk/ps2_data pair into bytes. Each 11-bit frame
// (start, 8 data bits LSB-first, odd parity, stop) is validated; a good frame
// produces one byte with a single-cycle strobe, bad or stalled frames raise
// an error strobe and the receiver waits for the next start bit.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   ps2_clk     raw PS/2 clock (asynchronous, idle high)
//   ps2_data    raw PS/2 data  (asynchronous, idle high)
//   byte_out    last good byte, held until the next good frame
//   byte_valid  one-cycle pulse, byte_out updated this cycle
//   parity_err  one-cycle pulse, good stop bit but wrong parity
//   frame_err   one-cycle pulse, stop bit 0 or frame timed out
//   busy        high while a frame is in progress
module ps2_byte_rx #(
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // The counter would reach TIMEOUT_CYCLES-1 on this increment: abort instead.
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_p0, sclk, sclk_d;
  logic          data_p0, sdata;
  logic          fall;

  state_t        state, state_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic          par, par_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [7:0]    byte_nxt;
  logic          valid_nxt, perr_nxt, ferr_nxt;

  // ---- stage: synchronisers and falling-edge detect ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_p0  <= 1'b1;
      sclk    <= 1'b1;
      sclk_d  <= 1'b1;
      data_p0 <= 1'b1;
      sdata   <= 1'b1;
    end else begin
      clk_p0  <= ps2_clk;
      sclk    <= clk_p0;
      sclk_d  <= sclk;
      data_p0 <= ps2_data;
      sdata   <= data_p0;
    end
  end

  assign fall = sclk_d & ~sclk;

  // ---- stage: frame state machine, next-state logic ----
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    par_nxt     = par;
    tcnt_nxt    = tcnt;
    byte_nxt    = byte_out;
    valid_nxt   = 1'b0;
    perr_nxt    = 1'b0;
    ferr_nxt    = 1'b0;

    // A fall always wins over the timeout since it restarts the count.
    if (state == IDLE || fall) begin
      tcnt_nxt = '0;
    end else if (tcnt == TLIM) begin
      tcnt_nxt  = '0;
      state_nxt = IDLE;
      ferr_nxt  = 1'b1;
    end else begin
      tcnt_nxt = tcnt + 1'b1;
    end

    if (fall) begin
      unique case (state)
        IDLE: begin
          if (!sdata) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
          end
        end
        DATA: begin
          shift_nxt   = {sdata, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: begin
          par_nxt   = sdata;
          state_nxt = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          if (!sdata) begin
            ferr_nxt = 1'b1;
          end else if (^{shift, par}) begin
            byte_nxt  = shift;
            valid_nxt = 1'b1;
          end else begin
            perr_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---- stage: registered state and outputs ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      par        <= 1'b0;
      tcnt       <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift      <= shift_nxt;
      bit_cnt    <= bit_cnt_nxt;
      par        <= par_nxt;
      tcnt       <= tcnt_nxt;
      byte_out   <= byte_nxt;
      byte_valid <= valid_nxt;
      parity_err <= perr_nxt;
      frame_err  <= ferr_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_ps2_byte_rx.sv
// Testbench for ps2_byte_rx. The PS/2 device is modelled at frame level; each
// pin-level clock fall that matters schedules an expected event three clk
// cycles later (two synchroniser flops plus the registered outputs), and a
// monitor compares pulses, byte_out and busy on every cycle.
module tb_ps2_byte_rx;

  localparam int T = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] byte_out;
  logic       byte_valid, parity_err, frame_err, busy;

  ps2_byte_rx #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 frame start (busy rises), 1 good byte, 2 parity error, 3 frame error
  typedef struct {
    int         c;
    int         kind;
    logic [7:0] d;
  } ev_t;

  ev_t        q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_byte = 8'h00;
  logic       exp_busy = 1'b0;
  bit         mon_en = 1'b0;
  int         fc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Per-cycle monitor.
  initial begin
    ev_t        e;
    logic [2:0] ep;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        ep = 3'b000;
        while (q.size() > 0 && q[0].c <= cyc) begin
          e = q.pop_front();
          case (e.kind)
            0: exp_busy = 1'b1;
            1: begin ep[2] = 1'b1; exp_byte = e.d; exp_busy = 1'b0; end
            2: begin ep[1] = 1'b1; exp_busy = 1'b0; end
            default: begin ep[0] = 1'b1; exp_busy = 1'b0; end
          endcase
        end
        check("pulses", {29'd0, byte_valid, parity_err, frame_err}, {29'd0, ep});
        check("byte_out", {24'd0, byte_out}, {24'd0, exp_byte});
        check("busy", {31'd0, busy}, {31'd0, exp_busy});
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One device bit: data set while clock is high, then a low and high phase.
  task automatic pin_bit(input logic b, input int h, input int kind,
                         input logic [7:0] d, output int fall_cyc);
    ev_t e;
    ps2_data = b;
    wait_clk(h);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    if (kind >= 0) begin
      e.c = cyc + 3; e.kind = kind; e.d = d;
      q.push_back(e);
    end
    wait_clk(h);
    ps2_clk = 1'b1;
  endtask

  // mode 0: good, 1: wrong parity, 2: stop bit 0
  task automatic send_frame(input logic [7:0] d, input int mode, input int h);
    logic p;
    int   f;
    int   k;
    p = (mode == 1) ? ^d : ~^d;
    k = (mode == 2) ? 3 : (mode == 1) ? 2 : 1;
    pin_bit(1'b0, h, 0, d, f);
    for (int i = 0; i < 8; i++) pin_bit(d[i], h, -1, d, f);
    pin_bit(p, h, -1, d, f);
    pin_bit((mode == 2) ? 1'b0 : 1'b1, h, k, d, f);
    ps2_data = 1'b1;
  endtask

  initial begin
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;

    // Reset state
    wait_clk(3);
    check("rst_byte_out", {24'd0, byte_out}, 32'h0);
    check("rst_pulses", {29'd0, byte_valid, parity_err, frame_err}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    #2 reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    wait_clk(5);

    // Good frame 0x08, 40 clk per half-bit
    send_frame(8'h08, 0, 40);
    wait_clk(10);

    // Back-to-back frames
    send_frame(8'hA5, 0, 10);
    send_frame(8'h3C, 0, 10);
    send_frame(8'hFF, 0, 10);
    wait_clk(10);

    // Parity error, then framing error
    send_frame(8'h5A, 1, 8);
    wait_clk(10);
    send_frame(8'h5A, 2, 8);
    wait_clk(10);

    // Timeout after start + 4 data bits
    begin
      ev_t  e;
      logic [7:0] d;
      d = 8'h96;
      pin_bit(1'b0, 10, 0, d, fc);
      for (int i = 0; i < 4; i++) pin_bit(d[i], 10, -1, d, fc);
      e.c = fc + T + 2; e.kind = 3; e.d = d;
      q.push_back(e);
      ps2_data = 1'b1;
      wait_clk(T + 20);
    end
    send_frame(8'h12, 0, 6);
    wait_clk(10);

    // Ignored fall with data high while idle
    ps2_data = 1'b1;
    wait_clk(5);
    ps2_clk = 1'b0;
    wait_clk(5);
    ps2_clk = 1'b1;
    wait_clk(10);
    send_frame(8'h7E, 0, 5);
    wait_clk(10);

    // Reset mid-frame after 5 data bits of 0xC3
    pin_bit(1'b0, 40, 0, 8'hC3, fc);
    for (int i = 0; i < 5; i++) pin_bit(fc[0] ^ fc[0] ^ ((8'hC3 >> i) & 1) == 1, 40, -1, 8'hC3, fc);
    @(negedge clk);
    mon_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_byte_out", {24'd0, byte_out}, 32'h0);
    check("mid_rst_pulses", {29'd0, byte_valid, parity_err, frame_err}, 32'h0);
    check("mid_rst_busy", {31'd0, busy}, 32'h0);
    q.delete();
    exp_byte = 8'h00;
    exp_busy = 1'b0;
    ps2_data = 1'b1;
    wait_clk(3);
    #2 reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    wait_clk(10);
    send_frame(8'hC3, 0, 7);
    wait_clk(10);

    // Randomised frames: byte, error kind, bit rate and inter-frame gap
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      int         r;
      int         md;
      d  = 8'($urandom_range(0, 255));
      r  = int'($urandom_range(0, 3));
      md = (r < 2) ? 0 : r - 1;
      send_frame(d, md, int'($urandom_range(3, 12)));
      wait_clk(int'($urandom_range(0, 20)));
    end
    wait_clk(10);

    check("pending_events", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_byte_rx.md
# ps2_byte_rx

Bit-level PS/2 receiver that deserializes the device's ps2_clk/ps2_data line pair into bytes for the PS/2 message framer. It validates each 11-bit frame: start bit, 8 data bits LSB-first, odd parity and stop bit. For each good frame it emits one byte with a single-cycle valid strobe; that byte feeds the framer's 8-bit `in` input. Parity errors, framing errors and stalled frames are flagged, and the receiver resynchronises to the next start bit.

## Interface
- TIMEOUT_CYCLES, default 12000: clk cycles without a ps2_clk falling edge, inside a frame, before the frame is abandoned. Minimum legal value 2.
- clk  input  1  system clock; all state is clocked on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock from the device, asynchronous to clk, idle high.
- ps2_data  input  1  raw PS/2 data from the device, asynchronous to clk, idle high.
- byte_out  output  8  last correctly received byte; held until the next good frame.
- byte_valid  output  1  one-cycle pulse marking that byte_out was updated this cycle.
- parity_err  output  1  one-cycle pulse: stop bit was good but parity was wrong; frame discarded.
- frame_err  output  1  one-cycle pulse: stop bit was 0, or the frame timed out; frame discarded.
- busy  output  1  high while a frame is in progress (state is not IDLE).

## Operation
- Synchronisers:
  - ps2_clk and ps2_data each pass through two flops; both reset to 1.
  - A third flop holds the previous synchronised clock (sclk_d, reset 1).
  - fall = sclk_d & ~sclk. Data is sampled from the synchronised ps2_data (sdata) in the same cycle fall is high.
- State machine (reset value IDLE). Every state transition happens only on a cycle where fall is high, except the timeout.
  - IDLE:
    - fall with sdata=0 (start bit): go to DATA, clear bit_cnt.
    - fall with sdata=1: ignored, stay in IDLE.
  - DATA:
    - each fall does shift <= {sdata, shift[7:1]} (LSB arrives first) and bit_cnt += 1.
    - on the 8th data bit (bit_cnt==7 before the increment): go to PARITY.
  - PARITY: fall captures sdata into par, then go to STOP.
  - STOP: fall returns to IDLE and produces exactly one of the following:
    - sdata=1 and ^{shift,par}==1 (odd parity correct): byte_out <= shift, byte_valid pulse.
    - sdata=1 and parity wrong: parity_err pulse; byte_out unchanged.
    - sdata=0: frame_err pulse, whatever the parity; byte_out unchanged.
- Timeout:
  - tcnt (width $clog2(TIMEOUT_CYCLES+1)) clears on every fall and in IDLE.
  - In all other states it increments each cycle without a fall.
  - When tcnt reaches TIMEOUT_CYCLES-1 without a fall: go to IDLE, pulse frame_err, discard the partial frame.
  - The timeout cannot coincide with a fall, because a fall clears tcnt and takes priority.
- Reset mid-frame: asynchronously forces IDLE and clears everything:
  - shift, bit_cnt, tcnt and par all go to 0; the synchronisers go to 1.
  - byte_out goes to 0x00; byte_valid, parity_err and frame_err go to 0.
  - No pulse is generated on reset release.
- At most one of byte_valid, parity_err and frame_err is high in any cycle.
- busy = (state != IDLE), registered state decode.

## Timing
- Reset values: byte_out=0x00, byte_valid=0, parity_err=0, frame_err=0, busy=0.
- Edge detection: a ps2_clk falling edge that meets setup at clk edge k appears as fall during cycle k+2 (after two synchroniser stages plus the compare against sclk_d).
- Output timing: all outputs are registered. byte_valid/parity_err/frame_err rise in the cycle after the stop-bit fall cycle and last exactly one cycle.
- byte_out update: byte_out changes in the same cycle byte_valid rises.
- No backpressure: the consumer must accept a byte on any cycle byte_valid is high.
- Frame spacing: consecutive frames may be back-to-back. A start-bit fall arriving one cycle after the stop-bit fall is accepted.
- Bit rate: ps2_clk low and high phases are each at least 3 clk cycles. Shorter glitches are out of spec and not filtered.

## Test plan
- Good frame: send 0x08 with parity=0 (frame bits 0,0,0,0,1,0,0,0,0,0,1), 40 clk per half-bit. Required: one byte_valid pulse with byte_out=0x08 three clk cycles after the stop-bit ps2_clk fall; busy low afterwards.
- Back-to-back frames: 0xA5 (parity 1), then 0x3C (parity 1), then 0xFF (parity 1), with no idle gap. Required: three byte_valid pulses carrying 0xA5, 0x3C, 0xFF in order; no error pulses.
- Parity and framing errors:
  - 0x5A sent with parity=0 (wrong): parity_err pulses once, no byte_valid, byte_out keeps its previous value.
  - 0x5A with correct parity but stop=0: frame_err pulses once, parity_err stays 0.
- Timeout: with TIMEOUT_CYCLES=100, send a start bit plus 4 data bits, then hold ps2_clk high. Required:
  - frame_err pulses exactly 100 cycles after the last fall; busy then drops.
  - A following good frame 0x12 is received correctly.
- Ignored start and idle: a ps2_clk fall with ps2_data=1 while idle causes no state change (busy stays 0). A following frame 0x7E is received normally.
- Reset mid-frame: assert reset asynchronously (between clk edges) after 5 data bits of 0xC3. Required:
  - All outputs are 0 immediately; busy stays 0 after release.
  - No spurious pulse; a new frame 0xC3 is then received with byte_valid.
